// File: rtl/mem_bus_arbiter.sv
// Two-master (bridge M0, core M1) to one-slave Wishbone arbiter with round robin and ack timeout.
// Define ARB_BRIDGE_LOCK_EN to let m0_lock_i keep the core off the bus while the bridge loads.
module mem_bus_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m0_lock_i,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_stall_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGntM0 = 2'd1,
    StGntM1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_m1_q, last_m1_d;  // 1: last grant went to M1
  logic [CntW-1:0] cnt_q, cnt_d;

  logic m0_req, gnt_m0, gnt_m1, gnt_req, timeout, m1_allowed;

  assign m0_req  = m0_cyc_i & m0_stb_i;
  assign gnt_m0  = (state_q == StGntM0);
  assign gnt_m1  = (state_q == StGntM1);
  assign gnt_req = (gnt_m0 & m0_req) | (gnt_m1 & m1_req_i);
  // An ack in the final wait cycle wins over the timeout.
  assign timeout = gnt_req & ~s_ack_i & (cnt_q == CntMax);

`ifdef ARB_BRIDGE_LOCK_EN
  assign m1_allowed = ~m0_lock_i;
`else
  logic unused_lock;
  assign unused_lock = m0_lock_i;
  assign m1_allowed  = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      last_m1_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_m1_q <= last_m1_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_m1_d = last_m1_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (m0_req && m1_req_i && m1_allowed) begin
          state_d = last_m1_q ? StGntM0 : StGntM1;
        end else if (m0_req) begin
          state_d = StGntM0;
        end else if (m1_req_i && m1_allowed) begin
          state_d = StGntM1;
        end
      end
      StGntM0, StGntM1: begin
        // Completion, abort (request dropped) and timeout all return to IDLE.
        if (!gnt_req || s_ack_i || timeout) begin
          state_d   = StIdle;
          cnt_d     = '0;
          last_m1_d = gnt_m1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    m0_dat_o   = '0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_dat_o   = '0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    if (gnt_m0) begin
      s_cyc_o  = 1'b1;
      s_stb_o  = 1'b1;
      s_we_o   = m0_we_i;
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      m0_dat_o = s_dat_i;
      m0_ack_o = s_ack_i & m0_req;
      m0_err_o = timeout;
    end else if (gnt_m1) begin
      s_cyc_o  = 1'b1;
      s_stb_o  = 1'b1;
      s_we_o   = m1_we_i;
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      m1_dat_o = s_dat_i;
      m1_ack_o = s_ack_i & m1_req_i;
      m1_err_o = timeout;
    end
    m1_stall_o = m1_req_i & ~(gnt_m1 & (s_ack_i | timeout));
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: per-master expectation queues filled at issue time,
// popped by a monitor whenever a master sees ack/err; a bench slave serves a word memory.
module tb_mem_bus_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc_i, m0_stb_i, m0_we_i, m0_lock_i;
  logic [AW-1:0] m0_adr_i;
  logic [DW-1:0] m0_dat_i, m0_dat_o;
  logic          m0_ack_o, m0_err_o;
  logic          m1_req_i, m1_we_i;
  logic [AW-1:0] m1_adr_i;
  logic [DW-1:0] m1_dat_i, m1_dat_o;
  logic          m1_ack_o, m1_err_o, m1_stall_o;
  logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o, s_dat_i;

  mem_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_lock_i(m0_lock_i),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          log_id[$];
  int unsigned log_cyc[$];
  logic [31:0] ref_mem[256];
  logic [31:0] slv_mem[256];
  int          force_dly = -1;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Reference: bit 12 of an address marks a slave hole (never acks -> err); else a word memory.
  function automatic void push_exp(input int m, input logic we, input logic [31:0] adr,
                                   input logic [31:0] dat);
    exp_t e;
    e.err = adr[12];
    e.dat = 32'h0;
    if (!adr[12]) begin
      if (we) ref_mem[adr[9:2]] = dat;
      else e.dat = ref_mem[adr[9:2]];
    end
    if (m == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  // Bench slave: random or forced ack delay measured from the first strobe cycle.
  initial begin : slave
    bit busy, dead;
    int wcnt, dly;
    busy = 0; dead = 0; wcnt = 0; dly = 0;
    s_ack_i = 1'b0;
    s_dat_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (s_cyc_o && s_stb_o) begin
        if (!busy) begin
          busy = 1;
          wcnt = 0;
          dly  = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
          dead = s_adr_o[12];
        end else wcnt++;
      end else busy = 0;
      s_ack_i = busy && !dead && (wcnt == dly);
      s_dat_i = (s_ack_i && !s_we_o) ? slv_mem[s_adr_o[9:2]] : 32'h0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (s_cyc_o && s_ack_i && s_we_o) slv_mem[s_adr_o[9:2]] = s_dat_o;
  end

  // Monitor: pop and compare on every ack/err; also checks the core stall rule every cycle.
  initial forever begin : monitor
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (m0_ack_o || m0_err_o) begin
        if (q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL m0_unexpected: got ack=%0b err=%0b want none", m0_ack_o, m0_err_o);
        end else begin
          e = q0.pop_front();
          check("m0_err", 32'(m0_err_o), 32'(e.err));
          if (!e.err) check("m0_dat", m0_dat_o, e.dat);
          log_id.push_back(0);
          log_cyc.push_back(cyc_cnt);
        end
      end
      if (m1_ack_o || m1_err_o) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL m1_unexpected: got ack=%0b err=%0b want none", m1_ack_o, m1_err_o);
        end else begin
          e = q1.pop_front();
          check("m1_err", 32'(m1_err_o), 32'(e.err));
          if (!e.err) check("m1_dat", m1_dat_o, e.dat);
          log_id.push_back(1);
          log_cyc.push_back(cyc_cnt);
        end
      end
      check("m1_stall", 32'(m1_stall_o), 32'(m1_req_i && !(m1_ack_o || m1_err_o)));
    end
  end

  task automatic wait_resp(input int m);
    bit seen;
    seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = (m == 0) ? (m0_ack_o || m0_err_o) : (m1_ack_o || m1_err_o);
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL m%0d_resp_timeout: got no ack/err in 64 cycles want a response", m);
    end
  endtask

  task automatic m0_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input bit hold);
    push_exp(0, we, adr, dat);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
    wait_resp(0);
    @(posedge clk);
    #1;
    if (!hold) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
  endtask

  task automatic m1_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input bit hold);
    push_exp(1, we, adr, dat);
    m1_req_i = 1'b1; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
    wait_resp(1);
    @(posedge clk);
    #1;
    if (!hold) m1_req_i = 1'b0;
  endtask

  task automatic rand_m(input int m, input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      logic [31:0] adr;
      k = $urandom_range(0, 3);
      if (k > 0) begin
        repeat (k) @(posedge clk);
        #1;
      end
      adr = 32'((m * 128 + int'($urandom_range(0, 127))) << 2);
      if ($urandom_range(0, 9) == 0) adr[12] = 1'b1;
      if (m == 0) m0_txn(1'($urandom_range(0, 1)), adr, $urandom, 0);
      else m1_txn(1'($urandom_range(0, 1)), adr, $urandom, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete(); q1.delete(); log_id.delete(); log_cyc.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, bad;
    rst = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_lock_i = 0;
    m1_req_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 32'(i) * 32'h01010101 ^ 32'hA5A50000;
      slv_mem[i] = ref_mem[i];
    end
    ref_mem[4] = 32'hCAFEF00D;
    slv_mem[4] = 32'hCAFEF00D;
    #3;
    check("rst_cyc", 32'(s_cyc_o), 0);
    check("rst_adr", s_adr_o, 0);
    check("rst_acks", 32'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 0);
    m1_req_i = 1'b1;
    #1;
    check("rst_stall", 32'(m1_stall_o), 1);
    m1_req_i = 1'b0;
    do_reset();

    // Core read with a registered slave: stb at N+1, ack and stall release at N+2.
    force_dly = 1;
    push_exp(1, 0, 32'h10, 0);
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_adr_i = 32'h10;
    @(negedge clk);
    check("rd_stb_n", 32'(s_stb_o), 0);
    @(negedge clk);
    check("rd_stb_n1", 32'(s_stb_o), 1);
    check("rd_ack_n1", 32'(m1_ack_o), 0);
    @(negedge clk);
    check("rd_ack_n2", 32'(m1_ack_o), 1);
    @(posedge clk);
    #1;
    m1_req_i = 1'b0;

    // Bridge write: slave sees the bridge's values, one ack, core outputs untouched.
    push_exp(0, 1, 32'h3FC, 32'h12345678);
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 32'h3FC; m0_dat_i = 32'h12345678;
    n = 0; bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s_cyc_o) begin
        check("wr_we", 32'(s_we_o), 1);
        check("wr_adr", s_adr_o, 32'h3FC);
        check("wr_dat", s_dat_o, 32'h12345678);
      end
      n += int'(m0_ack_o);
      if (m1_ack_o || m1_err_o || m1_dat_o != 0) bad++;
      if (m0_ack_o) begin
        @(posedge clk);
        #1;
        m0_cyc_i = 0; m0_stb_i = 0;
      end
    end
    check("wr_ack_count", 32'(n), 1);
    check("wr_m1_quiet", 32'(bad), 0);
    m1_txn(0, 32'h3FC, 0, 0);

    // Slave never acks: err in the 16th grant cycle.
    push_exp(1, 0, 32'h1040, 0);
    m1_req_i = 1'b1; m1_adr_i = 32'h1040;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (s_cyc_o) n++;
      if (m1_err_o) break;
    end
    check("to_grant_cycles", 32'(n), 32'(TO));
    @(posedge clk);
    #1;
    m1_req_i = 1'b0;
    @(negedge clk);
    check("to_err_pulse", 32'(m1_err_o), 0);
    check("to_idle", 32'(s_cyc_o), 0);

    // Bridge aborts: idle after the abort cycle, no err; the abort counts as M0's turn.
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h1000;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    m0_cyc_i = 0; m0_stb_i = 0;
    repeat (2) @(negedge clk);
    check("abort_idle", 32'(s_cyc_o), 0);
    @(posedge clk);
    #1;
    log_id.delete(); log_cyc.delete();
    force_dly = 0;
    fork
      m0_txn(0, 32'h20, 0, 0);
      m1_txn(0, 32'h24, 0, 0);
    join
    check("abort_tie_winner", 32'(log_id.size() > 0 ? log_id[0] : -1), 1);

    // Reset while the bridge waits on a dead slave: cyc/stb drop without a clock edge.
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h1008;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_cyc", 32'(s_cyc_o), 0);
    check("arst_stb", 32'(s_stb_o), 0);
    m0_cyc_i = 0; m0_stb_i = 0;
    q0.delete(); q1.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      n += int'(m0_ack_o || m0_err_o);
    end
    check("arst_no_ack", 32'(n), 0);

    // Both masters request back to back from reset: M1, M0, M1, M0 with one idle cycle each.
    do_reset();
    force_dly = 1;
    fork
      begin m0_txn(0, 32'h30, 0, 1); m0_txn(0, 32'h34, 0, 0); end
      begin m1_txn(0, 32'h38, 0, 1); m1_txn(0, 32'h3C, 0, 0); end
    join
    check("rr_count", 32'(log_id.size()), 4);
    if (log_id.size() == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), 32'(log_id[i]), 32'(~i & 1));
      for (int i = 1; i < 4; i++) check($sformatf("rr_gap%0d", i), log_cyc[i] - log_cyc[i-1], 3);
    end

    // Bridge lock with core requesting and bridge idle.
    m0_lock_i = 1'b1;
    push_exp(1, 0, 32'h40, 0);
    m1_req_i = 1'b1; m1_we_i = 0; m1_adr_i = 32'h40;
`ifdef ARB_BRIDGE_LOCK_EN
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(s_cyc_o);
    end
    check("lock_no_grant", 32'(n), 0);
    @(posedge clk);
    #1;
    m0_lock_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("lock_release_grant", 32'(s_cyc_o), 1);
`else
    @(negedge clk);
    @(negedge clk);
    check("lock_ignored_grant", 32'(s_cyc_o), 1);
`endif
    check("lock_gnt_adr", s_adr_o, 32'h40);
    wait_resp(1);
    @(posedge clk);
    #1;
    m1_req_i = 1'b0;
    m0_lock_i = 1'b0;

    // Randomized concurrent traffic in disjoint address halves.
    force_dly = -1;
    fork
      rand_m(0, 40);
      rand_m(1, 40);
    join
    repeat (4) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 0);
    check("q1_drained", 32'(q1.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter placed in front of a shared memory (data or instruction `mem`).
- Masters: the UART-to-Wishbone bridge (M0) and the core memory port (M1).
- Serialises their accesses so both never drive the memory at once.
- Stalls the core while the bridge owns the memory.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- TIMEOUT_CYCLES, 16, maximum cycles to wait for slave ack before aborting with error; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- m0_cyc_i  in  1  bridge cycle.
- m0_stb_i  in  1  bridge strobe.
- m0_we_i  in  1  bridge write enable.
- m0_adr_i  in  ADDR_WIDTH  bridge address.
- m0_dat_i  in  DATA_WIDTH  bridge write data.
- m0_dat_o  out  DATA_WIDTH  read data to bridge.
- m0_ack_o  out  1  ack to bridge.
- m0_err_o  out  1  timeout error to bridge.
- m0_lock_i  in  1  bridge bus lock (used only with the optional feature).
- m1_req_i  in  1  core access request.
- m1_we_i  in  1  core write enable.
- m1_adr_i  in  ADDR_WIDTH  core address.
- m1_dat_i  in  DATA_WIDTH  core write data.
- m1_dat_o  out  DATA_WIDTH  read data to core.
- m1_ack_o  out  1  ack to core.
- m1_stall_o  out  1  core must hold its pipeline.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_we_o  out  1  slave write enable.
- s_adr_o  out  ADDR_WIDTH  slave address.
- s_dat_o  out  DATA_WIDTH  slave write data.
- s_dat_i  in  DATA_WIDTH  slave read data.
- s_ack_i  in  1  slave ack.

Behaviour:
- Requests: M0 requests when m0_cyc_i & m0_stb_i; M1 requests when m1_req_i.
- FSM states: IDLE, GNT_M0, GNT_M1. Registered state.
- Reset (async, rst=1): state=IDLE, last_grant=M0, timeout counter=0.
  - All outputs 0: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, both ack/err, m0_dat_o, m1_dat_o.
  - m1_stall_o = m1_req_i (combinational), so the core stays stalled while requesting.
- IDLE:
  - Only M0 requests -> GNT_M0; only M1 requests -> GNT_M1.
  - Both request -> grant the master that is not last_grant (round robin); after reset M1 wins the first tie.
  - No request -> stay IDLE.
  - Slave outputs are 0 in IDLE.
- GNT_x:
  - s_cyc_o=s_stb_o=1.
  - s_we_o, s_adr_o and s_dat_o are combinationally muxed from granted master x.
  - s_dat_i is forwarded to mx_dat_o and s_ack_i to mx_ack_o in the same cycle.
  - The non-granted master sees ack=0 and dat_o=0.
- Completion: s_ack_i=1 in GNT_x -> last_grant<=x, counter<=0, next state IDLE.
  - IDLE always lasts at least one cycle between transactions (bus turnaround).
  - Minimum latency: request at cycle N, strobe at N+1, ack earliest at N+1 (combinational slave) or N+2 (registered `mem`).
- Abort: granted master drops its request before ack -> IDLE next cycle; no ack or err forwarded; last_grant updated.
- Timeout:
  - Counter increments each GNT cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 without ack: one-cycle mx_err_o pulse, next state IDLE, counter cleared, last_grant updated.
  - Ack and timeout in the same cycle -> ack wins, no err.
- m1_stall_o = m1_req_i & ~(state==GNT_M1 & (s_ack_i | timeout)).
  - The core holds address and data stable while stalled.
- Master requirements: no request changes while granted except abort. s_we_o/s_adr_o/s_dat_o must be stable for the whole grant.
- Reset mid-transaction: immediate IDLE; slave sees cyc/stb drop asynchronously; no ack forwarded.

Optional Feature:
- Macro: ARB_BRIDGE_LOCK_EN.
- Defined:
  - While m0_lock_i=1, IDLE never grants M1, even on a tie or with M0 idle.
  - M1 stays stalled; this gives the bridge exclusive ownership during program loading.
  - A GNT_M1 already in progress completes normally.
- Not defined: m0_lock_i is ignored and pure round-robin applies.

Test Plan:
- Single core read, addr 0x10, slave acks one cycle after stb with 0xCAFEF00D -> s_stb_o at N+1, m1_ack_o with m1_dat_o=0xCAFEF00D at N+2, m1_stall_o low at N+2.
- Bridge write, addr 0x3FC, data 0x12345678 -> s_we_o=1 with those values; m0_ack_o pulses once; m1_* outputs stay 0.
- Both request every cycle from reset for 4 transactions -> grant order M1, M0, M1, M0, with one IDLE cycle between each.
- Slave never acks, TIMEOUT_CYCLES=16 -> after 15 GNT cycles m1_err_o pulses for 1 cycle, state returns to IDLE, m1_stall_o drops.
- rst asserted in GNT_M0 mid-wait -> s_cyc_o/s_stb_o drop to 0 without waiting for clk; state IDLE; no ack after release.
- With ARB_BRIDGE_LOCK_EN defined, m0_lock_i=1, M1 requesting, M0 idle for 20 cycles -> s_cyc_o stays 0 and m1_stall_o stays 1; lock released -> M1 granted next cycle.
